// File: rtl/adder_display_mux_pkg.sv
// Shared constants for the adder/BCD/seven-segment display slice:
// segment glyphs, BCD digit count helper and FSM state encoding.
package adder_display_mux_pkg;

  // Segment order is {a,b,c,d,e,f,g}, active-high.
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Each decimal digit is worth a bit over 3 binary bits, so ceil(bits/3) always suffices.
  function automatic int calc_cd(input int width);
    return (width + 1 + 2) / 3;
  endfunction

endpackage

// File: rtl/adder_display_mux_bcd_to_seg7.sv
// Combinational BCD digit to seven-segment decoder with dash and blank overrides.
module bcd_to_seg7
  import adder_display_mux_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  logic [6:0] glyph;

  // Glyph lookup, then dash takes priority over blanking.
  always_comb begin
    glyph = SEG_BLANK;
    case (digit)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_BLANK;
    endcase
    if (dash) begin
      seg = SEG_DASH;
    end else if (blank) begin
      seg = SEG_BLANK;
    end else begin
      seg = glyph;
    end
  end

endmodule

// File: rtl/adder_display_mux.sv
// Registered adder feeding a sequential double-dabble converter and a
// time-multiplexed seven-segment display with blanking and overflow dashes.
module adder_display_mux
  import adder_display_mux_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  x,
  input  logic [WIDTH-1:0]  y,
  input  logic              load,
  output logic              busy,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              overflow
);

  localparam int SW = WIDTH + 1;
  localparam int CD = calc_cd(WIDTH);
  localparam int BW = 4 * CD;
  localparam int CW = $clog2(SW + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]     LAST_ITER    = CW'(WIDTH);
  localparam logic [RW-1:0]     REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]     DIGIT_LAST   = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_ONE       = DIGITS'(1);

  function automatic logic [BW-1:0] dd_adjust(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    r = v;
    for (int i = 0; i < CD; i++) begin
      r[4*i +: 4] = (v[4*i +: 4] >= 4'd5) ? v[4*i +: 4] + 4'd3 : v[4*i +: 4];
    end
    return r;
  endfunction

  function automatic logic has_overflow(input logic [BW-1:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < CD; i++) begin
      r = r | ((i >= DIGITS) && (v[4*i +: 4] != 4'd0));
    end
    return r;
  endfunction

  state_t        state_r, state_s;
  logic [SW-1:0] sum_r, sum_s;
  logic [BW-1:0] bcd_r, bcd_s, adj_s;
  logic [CW-1:0] iter_r, iter_s;
  logic [BW-1:0] disp_r, disp_s;
  logic          ovf_s;
  logic [IW-1:0] idx_r, idx_s;
  logic [RW-1:0] refresh_r, refresh_s;
  logic [3:0]    digit_s;
  logic          nz_above_s, blank_s;
  logic [6:0]    seg_s;

  // Conversion FSM; display registers only change in DONE so partial values never show.
  always_comb begin
    state_s = state_r;
    sum_s   = sum_r;
    bcd_s   = bcd_r;
    iter_s  = iter_r;
    disp_s  = disp_r;
    ovf_s   = overflow;
    adj_s   = dd_adjust(bcd_r);
    case (state_r)
      IDLE: begin
        if (load) begin
          sum_s   = SW'(x) + SW'(y);
          bcd_s   = '0;
          iter_s  = '0;
          state_s = CONV;
        end else begin
          state_s = IDLE;
        end
      end
      CONV: begin
        bcd_s  = {adj_s[BW-2:0], sum_r[SW-1]};
        sum_s  = {sum_r[SW-2:0], 1'b0};
        iter_s = iter_r + CW'(1);
        if (iter_r == LAST_ITER) begin
          state_s = DONE;
        end else begin
          state_s = CONV;
        end
      end
      DONE: begin
        disp_s  = bcd_r;
        ovf_s   = has_overflow(bcd_r);
        state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Scan position and the digit it selects, evaluated on next-state values so an/seg stay aligned.
  always_comb begin
    idx_s      = idx_r;
    refresh_s  = refresh_r + RW'(1);
    digit_s    = 4'd0;
    nz_above_s = 1'b0;
    if (refresh_r == REFRESH_LAST) begin
      refresh_s = '0;
      if (idx_r == DIGIT_LAST) begin
        idx_s = '0;
      end else begin
        idx_s = idx_r + IW'(1);
      end
    end else begin
      idx_s = idx_r;
    end
    for (int i = 0; i < CD; i++) begin
      digit_s    = (i == int'(idx_s)) ? disp_s[4*i +: 4] : digit_s;
      nz_above_s = nz_above_s | ((i >= int'(idx_s)) && (disp_s[4*i +: 4] != 4'd0));
    end
    blank_s = (idx_s != '0) && !nz_above_s;
  end

  bcd_to_seg7 u_seg (
    .digit (digit_s),
    .blank (blank_s),
    .dash  (ovf_s),
    .seg   (seg_s)
  );

  // State, datapath and registered display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      sum_r     <= '0;
      bcd_r     <= '0;
      iter_r    <= '0;
      disp_r    <= '0;
      idx_r     <= '0;
      refresh_r <= '0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      an        <= AN_ONE;
      seg       <= SEG_0;
    end else begin
      state_r   <= state_s;
      sum_r     <= sum_s;
      bcd_r     <= bcd_s;
      iter_r    <= iter_s;
      disp_r    <= disp_s;
      idx_r     <= idx_s;
      refresh_r <= refresh_s;
      busy      <= (state_s != IDLE);
      overflow  <= ovf_s;
      an        <= AN_ONE << idx_s;
      seg       <= seg_s;
    end
  end

endmodule

// File: tb/tb_adder_display_mux.sv
// Self-checking bench: a 3-digit and a 2-digit instance share stimulus;
// a table of sums with hand-derived glyphs feeds a scoreboard queue.
module tb_adder_display_mux;

  localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001, S4 = 7'b0110011, S5 = 7'b1011011;
  localparam logic [6:0] S6 = 7'b1011111, S7 = 7'b1110000, S8 = 7'b1111111;
  localparam logic [6:0] S9 = 7'b1111011, BL = 7'b0000000, DA = 7'b0000001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [7:0] x = 8'd0;
  logic [7:0] y = 8'd0;
  logic       busy, busy2, ovf, ovf2;
  logic [6:0] seg, seg2;
  logic [2:0] an;
  logic [1:0] an2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_display_mux #(.WIDTH(8), .DIGITS(3), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .load(load),
    .busy(busy), .seg(seg), .an(an), .overflow(ovf)
  );

  adder_display_mux #(.WIDTH(8), .DIGITS(2), .REFRESH_DIV(4)) dut2 (
    .clk(clk), .rst(rst), .x(x), .y(y), .load(load),
    .busy(busy2), .seg(seg2), .an(an2), .overflow(ovf2)
  );

  typedef struct packed {
    logic [7:0]      x;
    logic [7:0]      y;
    logic [2:0][6:0] seg3;
    logic            ovf3;
    logic [1:0][6:0] seg2;
    logic            ovf2;
  } vec_t;

  vec_t tbl [9];
  vec_t sb_q [$];

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b,
                              input logic [6:0] d2, input logic [6:0] d1, input logic [6:0] d0,
                              input logic o3, input logic [6:0] e1, input logic [6:0] e0,
                              input logic o2);
    vec_t v;
    v.x = a; v.y = b;
    v.seg3 = {d2, d1, d0}; v.ovf3 = o3;
    v.seg2 = {e1, e0};     v.ovf2 = o2;
    return v;
  endfunction

  function automatic int idx3(input logic [2:0] a);
    case (a)
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Pops the next expectation and compares both instances across a full scan.
  task automatic check_display();
    vec_t v;
    logic [2:0] seen3;
    logic [1:0] seen2;
    int i3, i2;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      v = sb_q.pop_front();
      seen3 = 3'b000;
      seen2 = 2'b00;
      check("overflow3", ovf, v.ovf3);
      check("overflow2", ovf2, v.ovf2);
      for (int k = 0; k < 12; k++) begin
        check("an3_onehot", $onehot(an), 1);
        check("an2_onehot", $onehot(an2), 1);
        i3 = idx3(an);
        i2 = (an2 == 2'b10) ? 1 : 0;
        check($sformatf("seg3_d%0d_sum%0d", i3, v.x + v.y), seg, v.seg3[i3]);
        check($sformatf("seg2_d%0d_sum%0d", i2, v.x + v.y), seg2, v.seg2[i2]);
        seen3 = seen3 | an;
        seen2 = seen2 | an2;
        @(negedge clk);
      end
      check("scan_cover3", seen3, 3'b111);
      check("scan_cover2", seen2, 2'b11);
    end
  endtask

  // Drives one load, optionally re-pulses load during busy, checks busy length and the result.
  task automatic run_one(input vec_t v, input int poke);
    int n;
    x = v.x; y = v.y; load = 1'b1;
    sb_q.push_back(v);
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == poke) begin
        x = 8'd1; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    check($sformatf("busy_cycles_sum%0d", v.x + v.y), n, 10);
    check_display();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v7, v48;
    int n;
    tbl[0] = mk(8'd200, 8'd55,  S2, S5, S5, 1'b0, DA, DA, 1'b1);
    tbl[1] = mk(8'd7,   8'd0,   BL, BL, S7, 1'b0, BL, S7, 1'b0);
    tbl[2] = mk(8'd0,   8'd0,   BL, BL, S0, 1'b0, BL, S0, 1'b0);
    tbl[3] = mk(8'd99,  8'd1,   S1, S0, S0, 1'b0, DA, DA, 1'b1);
    tbl[4] = mk(8'd1,   8'd2,   BL, BL, S3, 1'b0, BL, S3, 1'b0);
    tbl[5] = mk(8'd40,  8'd8,   BL, S4, S8, 1'b0, S4, S8, 1'b0);
    tbl[6] = mk(8'd90,  8'd9,   BL, S9, S9, 1'b0, S9, S9, 1'b0);
    tbl[7] = mk(8'd100, 8'd5,   S1, S0, S5, 1'b0, DA, DA, 1'b1);
    tbl[8] = mk(8'd16,  8'd0,   BL, S1, S6, 1'b0, S1, S6, 1'b0);
    v7  = tbl[1];
    v48 = tbl[5];

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_an", an, 3'b001);
    check("rst_seg", seg, S0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_an2", an2, 2'b01);
    rst = 1'b0;

    // Scan wrap with no loads: an advances exactly every 4 cycles.
    for (int k = 0; k < 16; k++) begin
      check($sformatf("scan3_k%0d", k), an, 3'b001 << ((k / 4) % 3));
      check($sformatf("scan2_k%0d", k), an2, 2'b01 << ((k / 4) % 2));
      check($sformatf("scan_seg_k%0d", k), seg, (k / 4) % 3 == 0 ? S0 : BL);
      @(negedge clk);
    end

    for (int i = 0; i < 9; i++) begin
      run_one(tbl[i], 0);
    end

    // Load re-pulsed with x=1 during busy must be ignored: 255+255 still shows 510.
    run_one(mk(8'd255, 8'd255, S5, S1, S0, 1'b0, DA, DA, 1'b1), 3);

    // Load raised in the DONE cycle is ignored there and accepted one cycle later.
    x = v7.x; y = v7.y; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == 10) begin
        x = v48.x; y = v48.y; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    check("done_busy_cycles", n, 10);
    check("done_load_ignored", busy, 1'b0);
    check("done_display7", seg, v7.seg3[idx3(an)]);
    @(negedge clk);
    check("load_after_done_accepted", busy, 1'b1);
    load = 1'b0;
    sb_q.push_back(v48);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles_after_done", n, 10);
    check_display();

    // Reset mid-conversion aborts and the display returns to "0".
    x = 8'd255; y = 8'd255; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy_before", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_seg", seg, S0);
    check("abort_an", an, 3'b001);
    check("abort_ovf", ovf, 1'b0);
    check("abort_ovf2", ovf2, 1'b0);
    repeat (20) @(negedge clk);
    check("abort_busy_later", busy, 1'b0);
    sb_q.push_back(mk(8'd0, 8'd0, BL, BL, S0, 1'b0, BL, S0, 1'b0));
    check_display();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
